// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the register-file write port between pipeline writeback and queued
// long-latency results, and keeps the busy scoreboard that drives decode stalls.
module regfile_wb_scheduler #(
   parameter int XLEN     = 32,
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wb_valid,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            wb_ready,
   input  logic            llu_issue,
   input  logic [4:0]      llu_issue_rd,
   input  logic            llu_res_valid,
   input  logic [4:0]      llu_res_rd,
   input  logic [XLEN-1:0] llu_res_data,
   output logic            llu_res_ready,
   input  logic [4:0]      dec_rs1_addr,
   input  logic [4:0]      dec_rs2_addr,
   input  logic [4:0]      dec_rd_addr,
   input  logic            dec_rs1_used,
   input  logic            dec_rs2_used,
   input  logic            dec_rd_we,
   output logic            dec_stall,
   output logic            rf_regWrite,
   output logic [4:0]      rf_rd_addr,
   output logic [XLEN-1:0] rf_rd_data
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int WW = $clog2(MAX_WAIT + 1);

   logic [XLEN-1:0] fifo_data_q [DEPTH];
   logic [4:0]      fifo_rd_q   [DEPTH];
   logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [WW-1:0]   wait_q, wait_d;
   logic [31:0]     busy_q, busy_d;
   logic            rf_we_q, rf_we_d;
   logic [4:0]      rf_addr_q, rf_addr_d;
   logic [XLEN-1:0] rf_data_q, rf_data_d;
   logic            src_llu_q, src_llu_d;

   logic fifo_empty, starve, push, wb_grant, fifo_grant;

   assign fifo_empty    = (count_q == '0);
   assign starve        = !fifo_empty && (wait_q == WW'(MAX_WAIT));
   assign wb_ready      = !starve;
   assign llu_res_ready = (count_q < CW'(DEPTH));
   // Results addressed to x0 complete the handshake but never occupy a slot.
   assign push          = llu_res_valid && llu_res_ready && (llu_res_rd != 5'd0);
   // A WB to x0 is accepted without using the port, leaving it to the FIFO.
   assign wb_grant      = wb_valid && wb_ready && (wb_rd != 5'd0);
   assign fifo_grant    = !wb_grant && !fifo_empty;

   assign dec_stall = (dec_rs1_used && busy_q[dec_rs1_addr]) |
                      (dec_rs2_used && busy_q[dec_rs2_addr]) |
                      (dec_rd_we    && busy_q[dec_rd_addr]);

   assign rf_regWrite = rf_we_q;
   assign rf_rd_addr  = rf_addr_q;
   assign rf_rd_data  = rf_data_q;

   always_comb begin
      rf_we_d   = 1'b0;
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
      src_llu_d = 1'b0;
      if (wb_grant) begin
         rf_we_d   = 1'b1;
         rf_addr_d = wb_rd;
         rf_data_d = wb_data;
      end else if (fifo_grant) begin
         rf_we_d   = 1'b1;
         rf_addr_d = fifo_rd_q[rptr_q];
         rf_data_d = fifo_data_q[rptr_q];
         src_llu_d = 1'b1;
      end
   end

   always_comb begin
      wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
      rptr_d  = fifo_grant ? rptr_q + PW'(1) : rptr_q;
      count_d = count_q + CW'(push) - CW'(fifo_grant);
      wait_d  = wait_q;
      if (fifo_grant || fifo_empty)
         wait_d = '0;
      else if (wait_q != WW'(MAX_WAIT))
         wait_d = wait_q + WW'(1);
   end

   // Clear lands on the edge the RF is written; a same-edge re-issue wins.
   always_comb begin
      busy_d = busy_q;
      if (rf_we_q && src_llu_q)
         busy_d[rf_addr_q] = 1'b0;
      if (llu_issue)
         busy_d[llu_issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         wait_q    <= '0;
         busy_q    <= '0;
         rf_we_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
         src_llu_q <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         wait_q    <= wait_d;
         busy_q    <= busy_d;
         rf_we_q   <= rf_we_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
         src_llu_q <= src_llu_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd_q[wptr_q]   <= llu_res_rd;
         fifo_data_q[wptr_q] <= llu_res_data;
      end
   end

endmodule
